motor_pwm_bank: RTL and testbench



---
 rtl/motor_pwm_bank.sv | 198 +++++++++++++++++++
 tb/tb_motor_pwm_bank.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_pwm_bank.sv
// motor_pwm_bank: N-channel H-bridge PWM generator sharing one period counter.
// Each channel takes a signed duty command and double-buffers it. The command
// becomes active only at the period boundary. Its magnitude is saturated to
// full scale. A programmable dead-time is inserted on every direction reversal.
// Optional feature macro: MOTOR_PWM_BRAKE_EN adds a per-channel brake input and
// a BRAKE state that drives both pins high (low-side short).
module motor_pwm_bank #(
  parameter int NUM_CH = 2,
  parameter int PWM_W  = 8,
  parameter int DT_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pwm_en,
  input  logic [NUM_CH*(PWM_W+1)-1:0] duty_in,
  input  logic [NUM_CH-1:0]           duty_wr,
  input  logic [DT_W-1:0]             deadtime,
`ifdef MOTOR_PWM_BRAKE_EN
  input  logic [NUM_CH-1:0]           brake,
`endif
  output logic                        period_end,
  output logic [NUM_CH-1:0]           motor_positive,
  output logic [NUM_CH-1:0]           motor_negative
);

  localparam int DW = PWM_W + 1;
  localparam logic [PWM_W-1:0] MAX = {{(PWM_W-1){1'b1}}, 1'b0};

`ifdef MOTOR_PWM_BRAKE_EN
  typedef enum logic [2:0] {ST_IDLE, ST_FWD, ST_REV, ST_DEAD, ST_BRAKE} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_REV, ST_DEAD} state_t;
`endif

  logic [PWM_W-1:0] cnt;
  logic             wrap;

  assign wrap       = pwm_en && (cnt == MAX);
  assign period_end = wrap;

  // Shared period counter: runs 0..MAX while enabled and parks at 0 when disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (!pwm_en || cnt == MAX)
      cnt <= '0;
    else
      cnt <= cnt + PWM_W'(1);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DW-1:0]        duty_k;
    logic signed [DW-1:0] shadow;
    logic signed [DW-1:0] active;
    logic [DW-1:0]        act_u;
    logic [DW-1:0]        abs_val;
    logic [PWM_W-1:0]     mag;
    logic                 raw;
    logic                 is_zero;
    logic                 is_neg;
    logic                 is_pos;
    logic                 brk;
    logic                 go;
    state_t               state;
    state_t               state_nxt;
    state_t               want;
    logic [DT_W-1:0]      dead_cnt;
    logic [DT_W-1:0]      dead_nxt;
    logic                 pos_q;
    logic                 neg_q;
    logic                 pos_nxt;
    logic                 neg_nxt;

    assign duty_k  = duty_in[k*DW +: DW];
    assign act_u   = active;
    assign abs_val = active[DW-1] ? (~act_u + DW'(1)) : act_u;
    assign mag     = abs_val[PWM_W] ? '1 : abs_val[PWM_W-1:0];
    assign raw     = (cnt < mag);
    assign is_neg  = active[DW-1];
    assign is_zero = (active == '0);
    assign is_pos  = !is_neg && !is_zero;
`ifdef MOTOR_PWM_BRAKE_EN
    assign brk     = brake[k];
`else
    assign brk     = 1'b0;
`endif

    // Double buffer: writes land in shadow; active only changes at the wrap,
    // and a write on the wrap clock bypasses straight into active as well.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (duty_wr[k])
          shadow <= duty_k;
        if (wrap)
          active <= duty_wr[k] ? duty_k : shadow;
      end
    end

    // Channel FSM next state and next pin values; the dead interval always
    // heads for whatever the current sign (or brake) asks for, so a sign
    // change during DEAD retargets without restarting the count.
    always_comb begin
      state_nxt = state;
      dead_nxt  = dead_cnt;
      go        = 1'b0;
      want      = is_neg ? ST_REV : (is_pos ? ST_FWD : ST_IDLE);
`ifdef MOTOR_PWM_BRAKE_EN
      if (brk)
        want = ST_BRAKE;
`endif
      if (!pwm_en) begin
        state_nxt = ST_IDLE;
        dead_nxt  = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (brk)
              go = 1'b1;
            else
              state_nxt = want;
          end
          ST_FWD: begin
            if (brk || is_neg)
              go = 1'b1;
            else if (is_zero)
              state_nxt = ST_IDLE;
          end
          ST_REV: begin
            if (brk || is_pos)
              go = 1'b1;
            else if (is_zero)
              state_nxt = ST_IDLE;
          end
          ST_DEAD: begin
            if (!brk && is_zero) begin
              state_nxt = ST_IDLE;
              dead_nxt  = '0;
            end else if (dead_cnt <= DT_W'(1)) begin
              state_nxt = want;
              dead_nxt  = '0;
            end else begin
              dead_nxt  = dead_cnt - DT_W'(1);
            end
          end
`ifdef MOTOR_PWM_BRAKE_EN
          ST_BRAKE: begin
            if (!brk) begin
              if (is_zero)
                state_nxt = ST_IDLE;
              else
                go = 1'b1;
            end
          end
`endif
          default: state_nxt = ST_IDLE;
        endcase
        if (go) begin
          if (deadtime == '0) begin
            state_nxt = want;
          end else begin
            state_nxt = ST_DEAD;
            dead_nxt  = deadtime;
          end
        end
      end
      pos_nxt = (state_nxt == ST_FWD) && raw;
      neg_nxt = (state_nxt == ST_REV) && raw;
`ifdef MOTOR_PWM_BRAKE_EN
      if (state_nxt == ST_BRAKE) begin
        pos_nxt = 1'b1;
        neg_nxt = 1'b1;
      end
`endif
    end

    // State, dead counter and registered pins; pins therefore lag cnt by one clock.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= ST_IDLE;
        dead_cnt <= '0;
        pos_q    <= 1'b0;
        neg_q    <= 1'b0;
      end else begin
        state    <= state_nxt;
        dead_cnt <= dead_nxt;
        pos_q    <= pos_nxt;
        neg_q    <= neg_nxt;
      end
    end

    assign motor_positive[k] = pos_q;
    assign motor_negative[k] = neg_q;
  end

endmodule

// File: tb/tb_motor_pwm_bank.sv
// tb_motor_pwm_bank: directed scenarios for motor_pwm_bank (NUM_CH=2, PWM_W=8).
// The stimulus side pushes the expected pins and period_end for every cycle,
// taken from hand-derived on-windows per channel; a monitor pops and compares.
module tb_motor_pwm_bank;

  localparam int MAX = 254;

  typedef enum {P_ZERO, P_POS, P_NEG, P_BOTH} pat_kind_e;

  typedef struct {
    pat_kind_e kind;
    int        lo;
    int        hi;
  } pat_t;

  typedef struct {
    string      name;
    int         cyc;
    logic       pe;
    logic [1:0] pos;
    logic [1:0] neg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_en;
  logic [17:0] duty_in;
  logic [1:0]  duty_wr;
  logic [3:0]  deadtime;
`ifdef MOTOR_PWM_BRAKE_EN
  logic [1:0]  brake;
`endif
  logic        period_end;
  logic [1:0]  motor_positive;
  logic [1:0]  motor_negative;

  exp_t  sb[$];
  pat_t  pat[2];
  int    tb_cnt;
  int    cyc;
  int    n_checks;
  int    n_pass;
  string scen;

  motor_pwm_bank #(.NUM_CH(2), .PWM_W(8), .DT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pwm_en         (pwm_en),
    .duty_in        (duty_in),
    .duty_wr        (duty_wr),
    .deadtime       (deadtime),
`ifdef MOTOR_PWM_BRAKE_EN
    .brake          (brake),
`endif
    .period_end     (period_end),
    .motor_positive (motor_positive),
    .motor_negative (motor_negative)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Expected {pos, neg} for one channel at bench counter value c.
  function automatic logic [1:0] pinExp(input pat_t p, input int c);
    logic in_win;
    in_win = (c >= p.lo) && (c <= p.hi);
    case (p.kind)
      P_POS:   return {in_win, 1'b0};
      P_NEG:   return {1'b0, in_win};
      P_BOTH:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic setPat(input int k, input pat_kind_e kind, input int lo, input int hi);
    pat[k].kind = kind;
    pat[k].lo   = lo;
    pat[k].hi   = hi;
  endtask

  // Push the expectation for the current cycle, advance the bench counter
  // with the inputs the coming posedge will sample, then wait a cycle.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t       e;
      logic [1:0] pn;
      e.name = scen;
      e.cyc  = cyc;
      e.pe   = pwm_en && !rst && (tb_cnt == MAX);
      for (int k = 0; k < 2; k++) begin
        pn       = pinExp(pat[k], tb_cnt);
        e.pos[k] = pn[1];
        e.neg[k] = pn[0];
      end
      sb.push_back(e);
      if (rst || !pwm_en || tb_cnt == MAX)
        tb_cnt = 0;
      else
        tb_cnt++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic runUntil(input int target);
    int guard;
    guard = 0;
    while (tb_cnt != target && guard < 300) begin
      applyStimulus(1);
      guard++;
    end
  endtask

  task automatic writeDuty(input int k, input int val);
    logic [8:0] v;
    v = 9'(val);
    duty_in[k*9 +: 9] = v;
    duty_wr = 2'b00;
    duty_wr[k] = 1'b1;
    applyStimulus(1);
    duty_wr = 2'b00;
  endtask

  // Reset asserted mid-cycle while outputs are active: expect zeros at once.
  task automatic applyAsyncReset();
    exp_t e;
    e.name = "async reset";
    e.cyc  = cyc;
    e.pe   = 1'b0;
    e.pos  = 2'b00;
    e.neg  = 2'b00;
    sb.push_back(e);
    #1;
    rst = 1'b1;
    tb_cnt = 0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic checkOutput(input exp_t e);
    n_checks++;
    if (period_end === e.pe && motor_positive === e.pos && motor_negative === e.neg)
      n_pass++;
    else
      $display("[TB] FAIL %s cycle %0d: pe/pos/neg actual %b/%b/%b required %b/%b/%b",
               e.name, e.cyc, period_end, motor_positive, motor_negative, e.pe, e.pos, e.neg);
  endtask

  // Monitor: sample away from the posedge and compare against the scoreboard.
  always @(negedge clk) begin
    #2;
    if (sb.size() > 0)
      checkOutput(sb.pop_front());
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; pwm_en = 1'b0; duty_in = '0; duty_wr = '0; deadtime = '0;
`ifdef MOTOR_PWM_BRAKE_EN
    brake = '0;
`endif
    tb_cnt = 0; cyc = 0; n_checks = 0; n_pass = 0;
    setPat(0, P_ZERO, 0, 0);
    setPat(1, P_ZERO, 0, 0);
    @(negedge clk);

    scen = "reset state";
    applyStimulus(3);

    $display("[TB] forward duty +64 written mid-period");
    rst = 1'b0; pwm_en = 1'b1;
    scen = "fwd64 before wrap";
    runUntil(10);
    writeDuty(0, 64);
    runUntil(0);
    scen = "fwd64";
    setPat(0, P_POS, 1, 64);
    writeDuty(0, 128);
    runUntil(0);

    $display("[TB] reversal with dead-time 5");
    deadtime = 4'd5;
    scen = "fwd128";
    setPat(0, P_POS, 1, 128);
    runUntil(100);
    writeDuty(0, -128);
    runUntil(0);
    scen = "reversal dead5";
    setPat(0, P_NEG, 6, 128);
    applyStimulus(255);
    scen = "rev128";
    setPat(0, P_NEG, 1, 128);

    $display("[TB] saturation with write on the wrap cycle");
    runUntil(MAX);
    writeDuty(0, -256);
    scen = "sat first period";
    setPat(0, P_NEG, 1, 254);
    applyStimulus(255);
    scen = "sat steady";
    setPat(0, P_NEG, 0, 254);
    applyStimulus(255);

    $display("[TB] disable mid-period and resume");
    scen = "disable";
    runUntil(30);
    pwm_en = 1'b0;
    applyStimulus(1);
    setPat(0, P_ZERO, 0, 0);
    applyStimulus(5);
    pwm_en = 1'b1;
    scen = "re-enable";
    setPat(0, P_NEG, 1, 254);
    applyStimulus(255);
    setPat(0, P_NEG, 0, 254);

    $display("[TB] channel 1 load and independence");
    deadtime = 4'd3;
    scen = "ch1 load";
    writeDuty(1, 64);
    runUntil(0);
    scen = "ch1 fwd64";
    setPat(1, P_POS, 1, 64);
    applyStimulus(255);

`ifdef MOTOR_PWM_BRAKE_EN
    $display("[TB] brake on channel 1 with dead-time 3");
    scen = "brake apply";
    runUntil(20);
    brake = 2'b10;
    applyStimulus(1);
    setPat(1, P_ZERO, 0, 0);
    runUntil(24);
    scen = "brake hold";
    setPat(1, P_BOTH, 0, 0);
    runUntil(40);
    brake = 2'b00;
    applyStimulus(1);
    scen = "brake release";
    setPat(1, P_ZERO, 0, 0);
    runUntil(44);
    setPat(1, P_POS, 44, 64);
    runUntil(0);
    scen = "ch1 after brake";
    setPat(1, P_POS, 1, 64);
    applyStimulus(255);
`endif

    $display("[TB] channel 1 reversal with zero dead-time");
    deadtime = 4'd0;
    scen = "ch1 pre-reverse";
    runUntil(100);
    writeDuty(1, -64);
    runUntil(0);
    scen = "ch1 rev dead0";
    setPat(1, P_NEG, 1, 64);
    applyStimulus(255);

    $display("[TB] asynchronous reset mid-stream");
    scen = "pre-reset";
    runUntil(MAX);
    setPat(0, P_ZERO, 0, 0);
    setPat(1, P_ZERO, 0, 0);
    applyAsyncReset();
    scen = "held in reset";
    applyStimulus(2);
    rst = 1'b0;
    scen = "idle after reset";
    applyStimulus(300);

    repeat (2) @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
